hue_sweep: RTL and testbench
============================

# hue_sweep

Upstream colour source for the RGB PWM stage. It sweeps hue 0–359° around the HSV wheel at saturation = value = 100% and drives per-channel duty values (0..PWM_INTERVAL) straight into the three `pwm` instances. A run/pause input controls the sweep, and a load port jumps it to any hue.

## Interface
- `PWM_INTERVAL`, 1200: full-scale duty. Must be a multiple of 60; elaboration fails otherwise.
- `DEG_CYCLES`, 33_333: clk cycles per 1° step. 12 MHz / 360 gives ≈ 1 s per revolution. Must be ≥ 2.
- Derived:
  - `STEP` = PWM_INTERVAL/60.
  - `DW` = $clog2(PWM_INTERVAL+1).
- `clk`  in  1  system clock (12 MHz).
- `rst_n`  in  1  reset. **Synchronous, active-low.**
- `en`  in  1  1 = sweep runs; 0 = prescaler and hue hold.
- `load`  in  1  one-cycle request to jump to `hue_in`.
- `hue_in`  in  9  target hue. Values > 359 are ignored, and the load is dropped.
- `hue`  out  9  current hue, 0..359.
- `step_pulse`  out  1  high for one cycle whenever `hue` changes.
- `pwm_value_r`, `pwm_value_g`, `pwm_value_b`  out  DW  duty values for the R, G and B pwm stages.

## Operation
- Internal state:
  - prescaler `pre` (0..DEG_CYCLES-1)
  - `hue` (0..359)
  - `sector` (0..5), a 6-state FSM S0..S5
  - `offset` (0..59), so that hue = 60·sector + offset
- Tick: asserted when `en`=1 and `pre`==DEG_CYCLES-1.
  - On a tick, `pre`←0 and hue advances by 1.
  - When `en`=1 without a tick, `pre`←`pre`+1.
  - When `en`=0, everything holds.
- Hue advance:
  - offset<59: offset+1.
  - offset=59: offset←0 and sector advances S0→S1→…→S5→S0.
  - 359 wraps to 0 (S5 back to S0).
- Load:
  - `load`=1 with `hue_in`≤359: hue←hue_in and `pre`←0.
  - Sector and offset come from a threshold compare against 60/120/180/240/300; no divider.
  - Load wins over a simultaneous tick. Load works regardless of `en`.
  - A load to the current hue still pulses `step_pulse`.
  - An invalid load changes nothing; a tick in the same cycle proceeds normally.
- Ramps, computed from the registered sector/offset:
  - rise = offset·STEP
  - fall = PWM_INTERVAL − offset·STEP
  - max = PWM_INTERVAL
  - offset·STEP ≤ 59·STEP < PWM_INTERVAL, so there is no overflow in DW bits.
- Channel mapping (R, G, B):
  - S0: max, rise, 0
  - S1: fall, max, 0
  - S2: 0, max, rise
  - S3: 0, fall, max
  - S4: rise, 0, max
  - S5: max, 0, fall
- Continuity: channel values are continuous across sector boundaries. For example, at hue 59 G = 59·STEP, and at hue 60 R = PWM_INTERVAL, G = max.

## Timing
- Reset (`rst_n`=0 at an edge), effective at the next edge and regardless of `en` or `load`:
  - pre=0, hue=0, sector=S0, offset=0
  - step_pulse=0
  - pwm_value_r=PWM_INTERVAL, pwm_value_g=0, pwm_value_b=0
- Reset asserted mid-sweep discards all state. The sweep restarts from hue 0 with a full DEG_CYCLES wait before the first step.
- Hue register: updates on the tick/load edge. `step_pulse` is registered and is high exactly during the cycle in which the new `hue` is first visible.
- pwm values are registered and lag `hue` by one cycle. They change on the edge after the hue change and are otherwise stable, so there is no glitching into the pwm compare.
- Step spacing with `en` held high: hue steps exactly every DEG_CYCLES cycles. One revolution is 360·DEG_CYCLES cycles.
- Pausing with `en`=0 freezes `pre`. On resume, the remaining count continues and is not restarted.

## Test plan
- Reset release, with DEG_CYCLES=4 and PWM_INTERVAL=1200 (STEP=20):
  - Outputs read hue=0, r/g/b = 1200/0/0.
  - The first `step_pulse` arrives 4 cycles after `rst_n` rises.
  - hue=1, and one cycle later g=20.
- Full revolution, DEG_CYCLES=4:
  - Exactly 360 pulses in 1440 cycles. Hue wraps 359→0.
  - Sampled values:
    - hue 59: r/g/b = 1200/1180/0
    - hue 60: 1200/1200/0
    - hue 180: 0/1200/1200
    - hue 330: 1200/0/600
    - hue 359: 1200/0/20
- Load:
  - hue_in=240 produces hue=240 next cycle and step_pulse=1. One cycle later r/g/b = 0/0/1200.
  - The next step occurs DEG_CYCLES cycles after the load.
- Load colliding with a tick, hue_in=100: hue=100, not old hue+1, and `pre` restarts at 0.
- Invalid load of hue_in=400: no change. A concurrent tick still advances hue by 1.
- Pause/resume:
  - Drop `en` at pre=2 for 50 cycles: hue stays constant.
  - After resume, the step occurs 2 cycles later.
  - Asserting rst_n=0 mid-pause returns r/g/b to 1200/0/0 on the next edge.

Source files
------------

// File: rtl/hue_sweep.sv
// HSV hue sweeper at full saturation/value: steps hue every DEG_CYCLES clocks and
// produces registered R/G/B duty values for the downstream pwm stages.
module hue_sweep #(
    parameter  int PWM_INTERVAL = 1200,
    parameter  int DEG_CYCLES   = 33_333,
    localparam int STEP         = PWM_INTERVAL / 60,
    localparam int DW           = $clog2(PWM_INTERVAL + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          load,
    input  logic [8:0]    hue_in,
    output logic [8:0]    hue,
    output logic          step_pulse,
    output logic [DW-1:0] pwm_value_r,
    output logic [DW-1:0] pwm_value_g,
    output logic [DW-1:0] pwm_value_b
);

    localparam int PW = (DEG_CYCLES > 1) ? $clog2(DEG_CYCLES) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DEG_CYCLES - 1);
    localparam logic [DW-1:0] STEP_W   = DW'(STEP);
    localparam logic [DW-1:0] PWM_W    = DW'(PWM_INTERVAL);

    generate
        if (PWM_INTERVAL % 60 != 0 || PWM_INTERVAL < 60) begin : g_badInterval
            $error("hue_sweep: PWM_INTERVAL must be a positive multiple of 60");
        end
        if (DEG_CYCLES < 2) begin : g_badDegCycles
            $error("hue_sweep: DEG_CYCLES must be at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5} sector_t;

    logic [PW-1:0] pre_q;
    logic [8:0]    hue_q;
    sector_t       sector_q;
    logic [5:0]    offset_q;
    logic          stepPulse_q;
    logic [DW-1:0] pwmR_q, pwmG_q, pwmB_q;
    logic [DW-1:0] pwmR_d, pwmG_d, pwmB_d;

    logic          tick;
    logic          loadValid;
    sector_t       loadSector_d;
    logic [8:0]    loadBase_d;
    logic [5:0]    loadOffset_d;
    logic [DW-1:0] rise, fall;

    assign tick      = en && (pre_q == PRE_LAST);
    assign loadValid = load && (hue_in <= 9'd359);

    // Split a loaded hue into sector/offset with a threshold ladder instead of a divide.
    always_comb begin
        loadSector_d = S0;
        loadBase_d   = 9'd0;
        if (hue_in >= 9'd300) begin
            loadSector_d = S5;
            loadBase_d   = 9'd300;
        end else if (hue_in >= 9'd240) begin
            loadSector_d = S4;
            loadBase_d   = 9'd240;
        end else if (hue_in >= 9'd180) begin
            loadSector_d = S3;
            loadBase_d   = 9'd180;
        end else if (hue_in >= 9'd120) begin
            loadSector_d = S2;
            loadBase_d   = 9'd120;
        end else if (hue_in >= 9'd60) begin
            loadSector_d = S1;
            loadBase_d   = 9'd60;
        end
        loadOffset_d = 6'(hue_in - loadBase_d);
    end

    always_comb begin
        rise   = DW'(offset_q) * STEP_W;
        fall   = PWM_W - rise;
        pwmR_d = '0;
        pwmG_d = '0;
        pwmB_d = '0;
        case (sector_q)
            S0: begin pwmR_d = PWM_W; pwmG_d = rise;  end
            S1: begin pwmR_d = fall;  pwmG_d = PWM_W; end
            S2: begin pwmG_d = PWM_W; pwmB_d = rise;  end
            S3: begin pwmG_d = fall;  pwmB_d = PWM_W; end
            S4: begin pwmR_d = rise;  pwmB_d = PWM_W; end
            S5: begin pwmR_d = PWM_W; pwmB_d = fall;  end
            default: begin pwmR_d = PWM_W; end
        endcase
    end

    // Sector FSM plus prescaler; pwm registers sample the previous sector/offset,
    // so duties change one edge after the hue they belong to.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_q       <= '0;
            hue_q       <= 9'd0;
            sector_q    <= S0;
            offset_q    <= 6'd0;
            stepPulse_q <= 1'b0;
            pwmR_q      <= PWM_W;
            pwmG_q      <= '0;
            pwmB_q      <= '0;
        end else begin
            pwmR_q      <= pwmR_d;
            pwmG_q      <= pwmG_d;
            pwmB_q      <= pwmB_d;
            stepPulse_q <= 1'b0;
            if (loadValid) begin
                pre_q       <= '0;
                hue_q       <= hue_in;
                sector_q    <= loadSector_d;
                offset_q    <= loadOffset_d;
                stepPulse_q <= 1'b1;
            end else if (tick) begin
                pre_q       <= '0;
                stepPulse_q <= 1'b1;
                hue_q       <= (hue_q == 9'd359) ? 9'd0 : hue_q + 9'd1;
                if (offset_q == 6'd59) begin
                    offset_q <= 6'd0;
                    case (sector_q)
                        S0:      sector_q <= S1;
                        S1:      sector_q <= S2;
                        S2:      sector_q <= S3;
                        S3:      sector_q <= S4;
                        S4:      sector_q <= S5;
                        default: sector_q <= S0;
                    endcase
                end else begin
                    offset_q <= offset_q + 6'd1;
                end
            end else if (en) begin
                pre_q <= pre_q + PW'(1);
            end
        end
    end

    assign hue         = hue_q;
    assign step_pulse  = stepPulse_q;
    assign pwm_value_r = pwmR_q;
    assign pwm_value_g = pwmG_q;
    assign pwm_value_b = pwmB_q;

endmodule

// File: tb/tb_hue_sweep.sv
// Self-checking bench for hue_sweep: directed scenarios plus random traffic,
// all compared cycle by cycle against a hue-level reference model.
module tb_hue_sweep;

   localparam int PWM_INTERVAL = 1200;
   localparam int DEG_CYCLES   = 4;
   localparam int STEP         = PWM_INTERVAL / 60;
   localparam int DW           = $clog2(PWM_INTERVAL + 1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en = 1'b0;
   logic          load = 1'b0;
   logic [8:0]    hue_in = 9'd0;
   logic [8:0]    hue;
   logic          step_pulse;
   logic [DW-1:0] pwm_value_r, pwm_value_g, pwm_value_b;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state: current hue, prescaler count, pulse, and the hue the duties show.
   int mHue = 0;
   int mPre = 0;
   int mPulse = 0;
   int mPwmHue = 0;

   hue_sweep #(
      .PWM_INTERVAL(PWM_INTERVAL),
      .DEG_CYCLES(DEG_CYCLES)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .en(en),
      .load(load),
      .hue_in(hue_in),
      .hue(hue),
      .step_pulse(step_pulse),
      .pwm_value_r(pwm_value_r),
      .pwm_value_g(pwm_value_g),
      .pwm_value_b(pwm_value_b)
   );

   always #5 clk = ~clk;

   // Colour of a hue on the HSV wheel at full saturation and value.
   function automatic void rgbForHue(input int h, output int r, output int g, output int b);
      int sec, up, down;
      sec  = h / 60;
      up   = (h % 60) * STEP;
      down = PWM_INTERVAL - up;
      r = 0; g = 0; b = 0;
      case (sec)
         0: begin r = PWM_INTERVAL; g = up; end
         1: begin r = down; g = PWM_INTERVAL; end
         2: begin g = PWM_INTERVAL; b = up; end
         3: begin g = down; b = PWM_INTERVAL; end
         4: begin r = up; b = PWM_INTERVAL; end
         default: begin r = PWM_INTERVAL; b = down; end
      endcase
   endfunction

   task automatic checkOutput(input string tag, input int observed, input int expected);
      vectors++;
      if (observed != expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   // Drive one cycle of inputs, advance the model across the edge, then compare everything.
   task automatic applyStimulus(input bit rstN, input bit enI, input bit loadI, input int hueIn);
      int r, g, b;
      rst_n  = rstN;
      en     = enI;
      load   = loadI;
      hue_in = 9'(hueIn);
      @(posedge clk);
      if (!rstN) begin
         mHue = 0; mPre = 0; mPulse = 0; mPwmHue = 0;
      end else begin
         mPwmHue = mHue;
         if (loadI && hueIn <= 359) begin
            mHue = hueIn; mPre = 0; mPulse = 1;
         end else if (enI && mPre == DEG_CYCLES - 1) begin
            mHue = (mHue + 1) % 360; mPre = 0; mPulse = 1;
         end else begin
            if (enI) mPre++;
            mPulse = 0;
         end
      end
      #1;
      rgbForHue(mPwmHue, r, g, b);
      checkOutput("hue", int'(hue), mHue);
      checkOutput("step_pulse", int'(step_pulse), mPulse);
      checkOutput("pwm_r", int'(pwm_value_r), r);
      checkOutput("pwm_g", int'(pwm_value_g), g);
      checkOutput("pwm_b", int'(pwm_value_b), b);
   endtask

   // Run with en high until the model prescaler reaches the wanted count (bounded).
   task automatic runToPre(input int target);
      for (int i = 0; i < 2 * DEG_CYCLES && mPre != target; i++)
         applyStimulus(1, 1, 0, 0);
   endtask

   initial begin
      int pulses;
      int pauseHue;

      applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 1, 1, 200);
      checkOutput("reset_r", int'(pwm_value_r), PWM_INTERVAL);

      // Full revolution straight out of reset: first step on the 4th edge.
      pulses = 0;
      for (int c = 1; c <= 360 * DEG_CYCLES; c++) begin
         applyStimulus(1, 1, 0, 0);
         if (step_pulse) pulses++;
         if (c == DEG_CYCLES) checkOutput("first_step_hue", int'(hue), 1);
         if (c == DEG_CYCLES + 1) checkOutput("first_step_g", int'(pwm_value_g), STEP);
      end
      checkOutput("rev_pulses", pulses, 360);
      checkOutput("rev_wrap_hue", int'(hue), 0);

      // Valid load, then confirm spacing to the following step.
      runToPre(1);
      applyStimulus(1, 1, 1, 240);
      checkOutput("load240_hue", int'(hue), 240);
      applyStimulus(1, 1, 0, 0);
      checkOutput("load240_b", int'(pwm_value_b), PWM_INTERVAL);
      for (int i = 0; i < DEG_CYCLES - 1; i++) applyStimulus(1, 1, 0, 0);
      checkOutput("load240_next", int'(hue), 241);

      // Load colliding with a tick, then invalid load colliding with a tick.
      runToPre(DEG_CYCLES - 1);
      applyStimulus(1, 1, 1, 100);
      checkOutput("collide_hue", int'(hue), 100);
      runToPre(DEG_CYCLES - 1);
      applyStimulus(1, 1, 1, 400);
      checkOutput("invalid_hue", int'(hue), 101);

      // Load to the current hue still pulses; load works while paused.
      applyStimulus(1, 0, 1, 101);
      checkOutput("same_load_pulse", int'(step_pulse), 1);

      // Pause at pre=2 for 50 cycles, resume, then reset mid-pause.
      runToPre(2);
      pauseHue = int'(hue);
      for (int i = 0; i < 50; i++) applyStimulus(1, 0, 0, 0);
      checkOutput("pause_hold", int'(hue), pauseHue);
      applyStimulus(1, 1, 0, 0);
      applyStimulus(1, 1, 0, 0);
      checkOutput("resume_step", int'(hue), (pauseHue + 1) % 360);
      for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);
      checkOutput("midpause_rst_r", int'(pwm_value_r), PWM_INTERVAL);

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++)
         applyStimulus($urandom_range(0, 99) != 0,
                       $urandom_range(0, 7) != 0,
                       $urandom_range(0, 15) == 0,
                       int'($urandom_range(0, 511)));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
